// File: rtl/mem_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_queue
// Description : Request FIFO feeding a single-outstanding IDLE/ISSUE/WAIT
//               issue FSM with response forwarding and wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [31:0]                req_address,
    input  logic [31:0]                req_data,
    input  logic                       req_mode,
    output logic                       mem_valid,
    output logic [31:0]                mem_address,
    output logic [31:0]                mem_data,
    output logic                       mem_mode,
    input  logic                       mem_response,
    input  logic [31:0]                mem_rdata,
    output logic                       resp_valid,
    output logic [31:0]                resp_data,
    output logic                       timeout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] C_FULL      = CW'(DEPTH);
    localparam logic [WW-1:0] C_WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [WW-1:0]   r_wait;
    logic [31:0]     r_addr_q [DEPTH];
    logic [31:0]     r_data_q [DEPTH];
    logic            r_mode_q [DEPTH];

    logic            w_push;
    logic            w_pop;

    assign req_ready = (r_count != C_FULL);
    assign count     = r_count;
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_addr_q[r_wptr] <= req_address;
            r_data_q[r_wptr] <= req_data;
            r_mode_q[r_wptr] <= req_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_wait      <= '0;
            mem_valid   <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_mode    <= 1'b0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            timeout     <= 1'b0;
        end else begin
            mem_valid  <= 1'b0;
            resp_valid <= 1'b0;
            timeout    <= 1'b0;

            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        mem_address <= r_addr_q[r_rptr];
                        mem_data    <= r_data_q[r_rptr];
                        mem_mode    <= r_mode_q[r_rptr];
                        mem_valid   <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wait  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A response on the final wait cycle still wins over timeout.
                    if (mem_response) begin
                        resp_valid <= 1'b1;
                        resp_data  <= mem_mode ? 32'd0 : mem_rdata;
                        r_state    <= S_IDLE;
                    end else if (r_wait == C_WAIT_LAST) begin
                        timeout <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_queue
// Description : Self-checking bench for mem_req_queue against a transaction
//               level reference model (request queue + issue-age arithmetic).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_queue;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_address;
    logic [31:0] req_data;
    logic        req_mode;
    logic        mem_valid;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_mode;
    logic        mem_response;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        timeout;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    mem_req_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_address  (req_address),
        .req_data     (req_data),
        .req_mode     (req_mode),
        .mem_valid    (mem_valid),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_mode     (mem_mode),
        .mem_response (mem_response),
        .mem_rdata    (mem_rdata),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .timeout      (timeout),
        .count        (count)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        m;
    } req_t;

    // Reference model: queued requests plus the one in flight, tracked by its age in edges.
    req_t        mq[$];
    req_t        m_cur;
    bit          m_busy;
    int          m_pop_edge;
    int          edge_n;
    logic        e_mem_valid, e_resp_valid, e_timeout;
    logic [31:0] e_resp_data, e_addr, e_data;
    logic        e_mode;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic step();
        bit   ready;
        int   age;
        req_t r;
        ready = (mq.size() != DEPTH);
        @(posedge clk);
        edge_n++;
        if (rst) begin
            mq.delete();
            m_busy = 0;
            e_mem_valid = 0; e_resp_valid = 0; e_timeout = 0;
            e_resp_data = 0; e_addr = 0; e_data = 0; e_mode = 0;
        end else begin
            e_mem_valid = 0; e_resp_valid = 0; e_timeout = 0;
            if (m_busy) begin
                age = edge_n - m_pop_edge;
                if (mem_response && age >= 2) begin
                    m_busy = 0;
                    e_resp_valid = 1;
                    e_resp_data = m_cur.m ? 32'd0 : mem_rdata;
                end else if (age == TIMEOUT + 1) begin
                    m_busy = 0;
                    e_timeout = 1;
                end
            end else if (mq.size() != 0) begin
                m_cur = mq.pop_front();
                m_busy = 1;
                m_pop_edge = edge_n;
                e_mem_valid = 1;
                e_addr = m_cur.a; e_data = m_cur.d; e_mode = m_cur.m;
            end
            if (req_valid && ready) begin
                r.a = req_address; r.d = req_data; r.m = req_mode;
                mq.push_back(r);
            end
        end
        #1;
    endtask

    task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] d, input logic m);
        req_valid = v; req_address = a; req_data = d; req_mode = m;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(1'b1, 32'hABCD, 32'h1234, 1'b1);
        mem_response = 1'b1;
        step();
        step();
        rst = 1'b0;
        set_req(1'b0, 0, 0, 0);
        mem_response = 1'b0;
        n_checks++; if (count !== 0)        begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %b expected 0", mem_valid); end
        n_checks++; if (resp_valid !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got resp_valid=%b timeout=%b expected 0 0", resp_valid, timeout); end
        n_checks++; if (mem_address !== 0 || mem_data !== 0 || mem_mode !== 0 || resp_data !== 0) begin
            n_fail++; $display("FAIL reset_fields: got addr=%h data=%h mode=%b rdata=%h expected all 0", mem_address, mem_data, mem_mode, resp_data); end
        step();
        n_checks++; if (mem_valid !== 1'b0 || count !== 0) begin n_fail++; $display("FAIL reset_no_enqueue: got mem_valid=%b count=%0d expected 0 0", mem_valid, count); end
    endtask

    task automatic test_single_read();
        set_req(1'b1, 32'h10, 32'h0, 1'b0);
        step();
        set_req(1'b0, 0, 0, 0);
        n_checks++; if (mem_valid !== 1'b0 || count !== 1) begin n_fail++; $display("FAIL read_accept: got mem_valid=%b count=%0d expected 0 1", mem_valid, count); end
        step();
        n_checks++; if (mem_valid !== 1'b1 || mem_address !== 32'h10 || mem_mode !== 1'b0) begin
            n_fail++; $display("FAIL read_issue: got valid=%b addr=%h mode=%b expected 1 00000010 0", mem_valid, mem_address, mem_mode); end
        step();
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL read_valid_one_cycle: got %b expected 0", mem_valid); end
        mem_response = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_response = 1'b0; mem_rdata = 32'h0;
        n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL read_resp: got valid=%b data=%h expected 1 deadbeef", resp_valid, resp_data); end
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL read_count: got %0d expected 0", count); end
        step();
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL read_resp_pulse: got %b expected 0", resp_valid); end
    endtask

    task automatic test_write();
        set_req(1'b1, 32'h20, 32'h55, 1'b1);
        step();
        set_req(1'b0, 0, 0, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mem_mode !== 1'b1 || mem_data !== 32'h55 || mem_address !== 32'h20) begin
                n_fail++; $display("FAIL write_hold: got addr=%h data=%h mode=%b expected 00000020 00000055 1", mem_address, mem_data, mem_mode); end
            step();
        end
        mem_response = 1'b1; mem_rdata = 32'hCAFEF00D;
        step();
        mem_response = 1'b0;
        n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h0) begin
            n_fail++; $display("FAIL write_resp: got valid=%b data=%h expected 1 00000000", resp_valid, resp_data); end
        step();
    endtask

    task automatic test_full();
        int issued = 0;
        int done   = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, 32'h100 + i, $urandom, i[0]);
            if (i == 5) begin
                n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", req_ready); end
            end
            step();
            if (mem_valid) begin
                n_checks++; if (mem_address !== 32'h100 + issued) begin n_fail++; $display("FAIL full_order: got %h expected %h", mem_address, 32'h100 + issued); end
                issued++;
            end
        end
        set_req(1'b0, 0, 0, 0);
        n_checks++; if (count !== DEPTH) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", count, DEPTH); end
        mem_response = 1'b1;
        for (int s = 0; s < 30; s++) begin
            mem_rdata = $urandom;
            step();
            if (mem_valid) begin
                n_checks++; if (mem_address !== 32'h100 + issued) begin n_fail++; $display("FAIL full_order: got %h expected %h", mem_address, 32'h100 + issued); end
                issued++;
            end
            if (resp_valid) begin
                n_checks++; if (resp_data !== e_resp_data) begin n_fail++; $display("FAIL full_resp_data: got %h expected %h", resp_data, e_resp_data); end
                done++;
            end
        end
        mem_response = 1'b0;
        n_checks++; if (issued !== 5 || done !== 5) begin n_fail++; $display("FAIL full_completions: got issued=%0d done=%0d expected 5 5", issued, done); end
    endtask

    task automatic test_timeout();
        int t_pulses = 0, r_pulses = 0, a_pop, t_edge = -100, b_edge = -100;
        mem_response = 1'b0;
        set_req(1'b1, 32'h300, 32'h1, 1'b0);
        step();
        set_req(1'b1, 32'h304, 32'h2, 1'b0);
        step();
        set_req(1'b0, 0, 0, 0);
        a_pop = edge_n;
        n_checks++; if (mem_valid !== 1'b1 || mem_address !== 32'h300) begin n_fail++; $display("FAIL to_first_issue: got valid=%b addr=%h expected 1 00000300", mem_valid, mem_address); end
        for (int s = 0; s < 40; s++) begin
            step();
            if (timeout)    begin t_pulses++; t_edge = edge_n; end
            if (resp_valid) r_pulses++;
            if (mem_valid)  begin b_edge = edge_n; break; end
        end
        n_checks++; if (t_pulses !== 1 || r_pulses !== 0) begin n_fail++; $display("FAIL to_pulses: got timeout=%0d resp=%0d expected 1 0", t_pulses, r_pulses); end
        n_checks++; if (t_edge - a_pop !== TIMEOUT + 1) begin n_fail++; $display("FAIL to_latency: got %0d expected %0d", t_edge - a_pop, TIMEOUT + 1); end
        n_checks++; if (b_edge - t_edge !== 1 || mem_address !== 32'h304) begin n_fail++; $display("FAIL to_next_issue: got gap=%0d addr=%h expected 1 00000304", b_edge - t_edge, mem_address); end
        mem_response = 1'b1; mem_rdata = 32'h77;
        step();
        step();
        mem_response = 1'b0;
        n_checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h77) begin n_fail++; $display("FAIL to_second_resp: got valid=%b data=%h expected 1 00000077", resp_valid, resp_data); end
        step();
    endtask

    task automatic test_wrap();
        int acc = 0, iss = 0, cmp = 0;
        bit took;
        mem_response = 1'b1;
        for (int s = 0; s < 80 && cmp < 10; s++) begin
            set_req(acc < 10, 32'h200 + acc, $urandom, 1'($urandom_range(0, 1)));
            mem_rdata = $urandom;
            took = req_valid && req_ready;
            step();
            if (took) acc++;
            if (mem_valid) begin
                n_checks++; if (mem_address !== 32'h200 + iss) begin n_fail++; $display("FAIL wrap_order: got %h expected %h", mem_address, 32'h200 + iss); end
                iss++;
            end
            if (resp_valid) begin
                n_checks++; if (resp_data !== e_resp_data) begin n_fail++; $display("FAIL wrap_resp_data: got %h expected %h", resp_data, e_resp_data); end
                cmp++;
            end
            n_checks++; if (count > DEPTH || count !== mq.size()) begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", count, mq.size()); end
        end
        set_req(1'b0, 0, 0, 0);
        mem_response = 1'b0;
        n_checks++; if (acc !== 10 || cmp !== 10) begin n_fail++; $display("FAIL wrap_total: got accepted=%0d completed=%0d expected 10 10", acc, cmp); end
        step();
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 32'h400 + i, i, 1'b0);
            step();
        end
        set_req(1'b0, 0, 0, 0);
        step();
        n_checks++; if (count !== 2) begin n_fail++; $display("FAIL rmw_pre_count: got %0d expected 2", count); end
        rst = 1'b1;
        set_req(1'b1, 32'h4FF, 0, 0);
        step();
        rst = 1'b0;
        set_req(1'b0, 0, 0, 0);
        n_checks++; if (count !== 0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rmw_count: got count=%0d ready=%b expected 0 1", count, req_ready); end
        n_checks++; if (mem_valid !== 0 || resp_valid !== 0 || timeout !== 0 || mem_address !== 0) begin
            n_fail++; $display("FAIL rmw_outputs: got mv=%b rv=%b to=%b addr=%h expected 0 0 0 0", mem_valid, resp_valid, timeout, mem_address); end
        mem_response = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step();
            n_checks++; if (resp_valid !== 0 || mem_valid !== 0 || timeout !== 0) begin
                n_fail++; $display("FAIL rmw_late_resp: got rv=%b mv=%b to=%b expected 0 0 0", resp_valid, mem_valid, timeout); end
        end
        mem_response = 1'b0;
    endtask

    task automatic test_random();
        for (int s = 0; s < 600; s++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_req(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
            mem_response = (s < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
            mem_rdata = $urandom;
            step();
            n_checks++; if (count !== mq.size() || req_ready !== (mq.size() != DEPTH)) begin
                n_fail++; $display("FAIL rnd_count: got count=%0d ready=%b expected %0d %b", count, req_ready, mq.size(), mq.size() != DEPTH); end
            n_checks++; if (mem_valid !== e_mem_valid || resp_valid !== e_resp_valid || timeout !== e_timeout) begin
                n_fail++; $display("FAIL rnd_strobes: got mv=%b rv=%b to=%b expected %b %b %b", mem_valid, resp_valid, timeout, e_mem_valid, e_resp_valid, e_timeout); end
            n_checks++; if (mem_address !== e_addr || mem_data !== e_data || mem_mode !== e_mode) begin
                n_fail++; $display("FAIL rnd_fields: got %h %h %b expected %h %h %b", mem_address, mem_data, mem_mode, e_addr, e_data, e_mode); end
            if (e_resp_valid) begin
                n_checks++; if (resp_data !== e_resp_data) begin n_fail++; $display("FAIL rnd_resp_data: got %h expected %h", resp_data, e_resp_data); end
            end
        end
        rst = 1'b0;
        set_req(1'b0, 0, 0, 0);
        mem_response = 1'b0;
    endtask

    initial begin
        edge_n = 0;
        m_busy = 0;
        m_pop_edge = 0;
        rst = 1'b1;
        set_req(1'b0, 0, 0, 0);
        mem_response = 1'b0;
        mem_rdata = 32'h0;
        test_reset();
        test_single_read();
        test_write();
        test_full();
        test_timeout();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_req_queue.md
MEM_REQ_QUEUE -- requirements
Module: mem_req_queue

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO entries; SHALL be a power of two >= 2.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles spent in WAIT before a request is abandoned; SHALL be >= 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  upstream request present.
REQ-006 req_ready  output  1  queue accepts a request this cycle.
REQ-007 req_address  input  32  request address.
REQ-008 req_data  input  32  write data, ignored for reads.
REQ-009 req_mode  input  1  1 = write (RAM path), 0 = read (cache path).
REQ-010 mem_valid  output  1  one-cycle issue strobe to the cache/RAM stage.
REQ-011 mem_address, mem_data  output  32 each  issued request fields, held stable from issue until the request completes.
REQ-012 mem_mode  output  1  issued request mode, held with mem_address.
REQ-013 mem_response  input  1  completion pulse from the cache/RAM stage.
REQ-014 mem_rdata  input  32  read data from the cache, sampled with mem_response.
REQ-015 resp_valid  output  1  one-cycle completion strobe to upstream.
REQ-016 resp_data  output  32  read data for reads; 0 for writes.
REQ-017 timeout  output  1  one-cycle pulse on an abandoned request.
REQ-018 count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 FIFO: circular buffer with read and write pointers that wrap modulo DEPTH; count SHALL range from 0 to DEPTH.
REQ-020 req_ready SHALL equal (count != DEPTH), decoded combinationally from registered state; no bypass when full.
REQ-021 Enqueue SHALL occur on a clock edge where req_valid && req_ready; req_valid while full SHALL be ignored and nothing SHALL be stored.
REQ-022 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-023 FSM states: IDLE, ISSUE, WAIT.
REQ-024 IDLE, count != 0: on the edge, SHALL pop the head into mem_address, mem_data, mem_mode and go to ISSUE.
REQ-025 IDLE, count == 0: SHALL remain in IDLE.
REQ-026 ISSUE: mem_valid SHALL be 1 for exactly this one cycle; the next edge SHALL go to WAIT and clear the wait counter.
REQ-027 WAIT, mem_response == 1: SHALL go to IDLE and assert resp_valid for the following cycle; resp_data SHALL be mem_rdata if mem_mode == 0, else 0.
REQ-028 WAIT, no response: the wait counter SHALL increment each cycle.
REQ-029 WAIT, counter reaches TIMEOUT-1 without a response: SHALL go to IDLE, pulse timeout for one cycle, and not assert resp_valid.
REQ-030 mem_response SHALL be ignored in IDLE and ISSUE.
REQ-031 Ordering: requests SHALL issue strictly in FIFO order, with at most one request outstanding.
REQ-032 Latency, empty queue in IDLE: request accepted at edge N -> pop at edge N+1 -> mem_valid high during cycle N+1..N+2 -> earliest resp_valid one cycle after the mem_response edge.
REQ-033 Back-to-back: after completion, the next queued request SHALL be popped on the first IDLE edge; minimum issue spacing is 3 cycles.

Reset
REQ-034 While rst == 1 at an edge: pointers, count, and wait counter SHALL go to 0; state SHALL go to IDLE.
REQ-035 While rst == 1 at an edge: mem_valid, resp_valid, and timeout SHALL go to 0; mem_address, mem_data, mem_mode, and resp_data SHALL go to 0.
REQ-036 Reset during WAIT or ISSUE SHALL abandon the outstanding request without resp_valid or timeout.
REQ-037 Reset SHALL discard queued entries.
REQ-038 A request presented during reset SHALL NOT be enqueued.
REQ-039 req_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-040 Single read: enqueue {addr=0x10, mode=0}; mem_response=1 with mem_rdata=0xDEADBEEF two cycles after mem_valid -> resp_valid=1, resp_data=0xDEADBEEF, count back to 0.
REQ-041 Write: enqueue {addr=0x20, data=0x55, mode=1} -> mem_mode=1, mem_data=0x55 held through WAIT; on response, resp_valid=1 and resp_data=0.
REQ-042 Full: 5 requests with DEPTH=4 while the first is stalled in WAIT -> first popped, then 4 queued, req_ready=0, 6th request dropped; completions return in order.
REQ-043 Timeout: no mem_response for TIMEOUT=16 cycles -> timeout pulses exactly once, no resp_valid, next entry issues on the following IDLE edge.
REQ-044 Wrap: 10 sequential requests with immediate responses -> pointers wrap twice, issue order and addresses match enqueue order, count never exceeds 4.
REQ-045 Reset mid-WAIT: rst=1 for one cycle with 2 entries queued -> count=0, state IDLE, mem_valid, resp_valid, and timeout all 0; a late mem_response is ignored.
